// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 filter line-buffer scheduler.
// Holds the read FSM state encoding, the number of circular line buffers
// and the default frame geometry used as parameter defaults.
package img_pkg;

  localparam int NUM_LINEBUF    = 4;
  localparam int LINE_BYTES_DEF = 2835;  // 945 px * 3 B
  localparam int NUM_ROWS_DEF   = 630;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ROW_END,
    DONE
  } state_e;

endpackage

// File: rtl/img_wr_ctrl.sv
// Write-side controller for the four circular line buffers.
// Steps the write column across a row and the write line across the buffers.
// It also counts completed rows and owns s_axis_tready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             end-of-frame clear of all counters (from read FSM)
//   s_axis_tvalid     input byte valid
//   rows_released     rows the read side no longer needs
//   s_axis_tready     byte accepted when high with tvalid
//   wr_en / wr_addr   one-hot buffer write enable and write column
//   rows_written      completed rows in the current frame
module img_wr_ctrl
  import img_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   s_axis_tvalid,
  input  logic [ROW_W:0]         rows_released,
  output logic                   s_axis_tready,
  output logic [NUM_LINEBUF-1:0] wr_en,
  output logic [COL_W-1:0]       wr_addr,
  output logic [ROW_W:0]         rows_written
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_BYTES - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W:0]   ROW_ONE  = (ROW_W+1)'(1);
  localparam logic [ROW_W:0]   ROWS_MAX = (ROW_W+1)'(NUM_ROWS);
  localparam logic [ROW_W:0]   OCC_FULL = (ROW_W+1)'(NUM_LINEBUF);

  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [1:0]       wr_line_q, wr_line_d;
  logic [ROW_W:0]   rows_written_q, rows_written_d;
  logic [ROW_W:0]   occupancy;
  logic             hs;

  // Ready depends on registered counters only; rst gates it so no byte is
  // taken while the block is being reset.
  assign occupancy     = rows_written_q - rows_released;
  assign s_axis_tready = !rst && (occupancy < OCC_FULL) && (rows_written_q < ROWS_MAX);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign rows_written  = rows_written_q;
  assign wr_addr       = wr_col_q;

  always_comb begin
    wr_col_d       = wr_col_q;
    wr_line_d      = wr_line_q;
    rows_written_d = rows_written_q;
    wr_en          = '0;
    if (clear) begin
      wr_col_d       = '0;
      wr_line_d      = '0;
      rows_written_d = '0;
    end else if (hs) begin
      wr_en[wr_line_q] = 1'b1;
      if (wr_col_q == LAST_COL) begin
        wr_col_d       = '0;
        wr_line_d      = wr_line_q + 2'd1;
        rows_written_d = rows_written_q + ROW_ONE;
      end else begin
        wr_col_d = wr_col_q + COL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col_q       <= '0;
      wr_line_q      <= '0;
      rows_written_q <= '0;
    end else begin
      wr_col_q       <= wr_col_d;
      wr_line_q      <= wr_line_d;
      rows_written_q <= rows_written_d;
    end
  end

endmodule

// File: rtl/img_linebuf_sched.sv
// Line-buffer scheduler for the 3x3 image filter.
// Writes incoming pixel bytes round-robin into four circular line buffers.
// Reads a three-row window per output byte, with zero-pad flags at the top
// and bottom frame borders. Signals row and frame completion.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_axis_tvalid/tready       input byte handshake
//   wr_en, wr_addr             line-buffer write port
//   rd_en, rd_addr             read strobe/column to all four buffers
//   rd_top_line                buffer holding row r-1 (r, r+1 follow mod 4)
//   pad_top, pad_bot           zero the top / bottom window row
//   win_valid, win_last        window valid at RAM outputs, last byte of row
//   m_ready                    downstream can take a window
//   intr, frame_done           1-cycle row-complete / frame-complete pulses
module img_linebuf_sched
  import img_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [NUM_LINEBUF-1:0] wr_en,
  output logic [COL_W-1:0]       wr_addr,
  output logic                   rd_en,
  output logic [COL_W-1:0]       rd_addr,
  output logic [1:0]             rd_top_line,
  output logic                   pad_top,
  output logic                   pad_bot,
  output logic                   win_valid,
  output logic                   win_last,
  input  logic                   m_ready,
  output logic                   intr,
  output logic                   frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_BYTES - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W:0]   CNT_ONE  = (ROW_W+1)'(1);
  localparam logic [ROW_W:0]   CNT_TWO  = (ROW_W+1)'(2);
  localparam logic [ROW_W:0]   ROWS_MAX = (ROW_W+1)'(NUM_ROWS);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [ROW_W:0]   rows_released_q, rows_released_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic [ROW_W:0]   rows_written;
  logic [ROW_W:0]   rows_needed;
  logic [ROW_W:0]   row_plus2;
  logic             clear;
  logic             row_active;

  img_wr_ctrl #(
    .LINE_BYTES (LINE_BYTES),
    .NUM_ROWS   (NUM_ROWS),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_wr_ctrl (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .s_axis_tvalid (s_axis_tvalid),
    .rows_released (rows_released_q),
    .s_axis_tready (s_axis_tready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rows_written  (rows_written)
  );

  // Row r needs rows r-1..r+1 written; the last row only needs itself.
  assign row_plus2   = {1'b0, out_row_q} + CNT_TWO;
  assign rows_needed = (row_plus2 > ROWS_MAX) ? ROWS_MAX : row_plus2;

  // Window geometry is meaningful only while a row is being read; it stays
  // stable through ROW_END so the last win_valid sees the same flags.
  assign row_active  = (state_q == RUN) || (state_q == ROW_END);
  assign pad_top     = row_active && (out_row_q == '0);
  assign pad_bot     = row_active && (out_row_q == LAST_ROW);
  assign rd_top_line = row_active ? (out_row_q[1:0] + 2'd3) : 2'd0;
  assign rd_addr     = rd_col_q;
  assign win_valid   = win_valid_q;
  assign win_last    = win_last_q;

  always_comb begin
    state_d         = state_q;
    out_row_d       = out_row_q;
    rd_col_d        = rd_col_q;
    rows_released_d = rows_released_q;
    clear           = 1'b0;
    rd_en           = 1'b0;
    intr            = 1'b0;
    frame_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rows_written >= rows_needed) state_d = RUN;
      end
      RUN: begin
        rd_en = m_ready;
        if (m_ready) begin
          // rd_col holds on the last strobe; ROW_END rewinds it.
          if (rd_col_q == LAST_COL) state_d = ROW_END;
          else                      rd_col_d = rd_col_q + COL_ONE;
        end
      end
      ROW_END: begin
        intr      = 1'b1;
        out_row_d = out_row_q + ROW_ONE;
        rd_col_d  = '0;
        // Row r-1 is dead once row r is done; row 0 has no predecessor.
        if (out_row_q != '0) rows_released_d = rows_released_q + CNT_ONE;
        state_d = (out_row_q == LAST_ROW) ? DONE : IDLE;
      end
      DONE: begin
        frame_done      = 1'b1;
        clear           = 1'b1;
        out_row_d       = '0;
        rd_col_d        = '0;
        rows_released_d = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window output stage: RAM read data appears one cycle after rd_en
  always_comb begin
    win_valid_d = rd_en;
    win_last_d  = rd_en && (rd_col_q == LAST_COL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      out_row_q       <= '0;
      rd_col_q        <= '0;
      rows_released_q <= '0;
      win_valid_q     <= 1'b0;
      win_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_row_q       <= out_row_d;
      rd_col_q        <= rd_col_d;
      rows_released_q <= rows_released_d;
      win_valid_q     <= win_valid_d;
      win_last_q      <= win_last_d;
    end
  end

endmodule

// File: tb/tb_img_linebuf_sched.sv
// Directed bench for img_linebuf_sched with a 4-byte x 5-row frame.
module tb_img_linebuf_sched;

  localparam int LB = 4;
  localparam int NR = 5;
  localparam int CW = 12;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [3:0]    wr_en;
  logic [CW-1:0] wr_addr;
  logic          rd_en;
  logic [CW-1:0] rd_addr;
  logic [1:0]    rd_top_line;
  logic          pad_top, pad_bot;
  logic          win_valid, win_last;
  logic          m_ready;
  logic          intr, frame_done;

  always #5 clk = ~clk;

  img_linebuf_sched #(
    .LINE_BYTES (LB),
    .NUM_ROWS   (NR),
    .COL_W      (CW),
    .ROW_W      (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_top_line   (rd_top_line),
    .pad_top       (pad_top),
    .pad_bot       (pad_bot),
    .win_valid     (win_valid),
    .win_last      (win_last),
    .m_ready       (m_ready),
    .intr          (intr),
    .frame_done    (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // per-run event counters, all owned by the initial process
  int n_hs, n_rd, n_wv, n_wl, n_intr, n_fd, n_pt, n_pb, n_pb_early;
  int n_addr_err, strobe_k, last_intr_cyc, fd_cyc;

  // values sampled at the falling edge of the current cycle
  logic          s_tready, s_rd_en, s_pad_top, s_pad_bot, s_wv, s_wl, s_intr, s_fd;
  logic [3:0]    s_wr_en;
  logic [CW-1:0] s_wr_addr, s_rd_addr;
  logic [1:0]    s_top;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_hs = 0; n_rd = 0; n_wv = 0; n_wl = 0; n_intr = 0; n_fd = 0;
    n_pt = 0; n_pb = 0; n_pb_early = 0; n_addr_err = 0; strobe_k = 0;
    last_intr_cyc = -100; fd_cyc = -1;
  endtask

  // Sample the cycle driven by the current inputs, then move to the next
  // drive point just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_tready  = s_axis_tready;
    s_rd_en   = rd_en;
    s_pad_top = pad_top;
    s_pad_bot = pad_bot;
    s_wv      = win_valid;
    s_wl      = win_last;
    s_intr    = intr;
    s_fd      = frame_done;
    s_wr_en   = wr_en;
    s_wr_addr = wr_addr;
    s_rd_addr = rd_addr;
    s_top     = rd_top_line;
    if (s_axis_tvalid && s_tready) n_hs++;
    if (s_rd_en) begin
      n_rd++;
      if (int'(s_rd_addr) != (strobe_k % LB)) n_addr_err++;
      strobe_k++;
      if (s_pad_top) n_pt++;
      if (s_pad_bot) begin
        n_pb++;
        if (n_intr < NR - 1) n_pb_early++;
      end
    end
    if (s_wv) n_wv++;
    if (s_wl) n_wl++;
    if (s_intr) begin n_intr++; last_intr_cyc = cyc; end
    if (s_fd) begin n_fd++; fd_cyc = cyc; end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_axis_tvalid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clr_cnt();
  endtask

  // Feed exactly one frame and run until frame_done (bounded).
  task automatic run_frame(input bit toggle, input string tag);
    int fed;
    bit done;
    fed = 0; done = 0;
    clr_cnt();
    for (int i = 0; i < 400 && !done; i++) begin
      s_axis_tvalid = (fed < LB * NR);
      m_ready       = toggle ? (i % 2 == 0) : 1'b1;
      tick();
      fed = n_hs;
      if (n_fd > 0) done = 1;
    end
    s_axis_tvalid = 1'b0;
    m_ready       = 1'b1;
    tick(); tick();
    chk({tag, "_completed"}, int'(done), 1);
    chk({tag, "_bytes"},  n_hs,   LB * NR);
    chk({tag, "_rd_en"},  n_rd,   LB * NR);
    chk({tag, "_wvalid"}, n_wv,   LB * NR);
    chk({tag, "_wlast"},  n_wl,   NR);
    chk({tag, "_intr"},   n_intr, NR);
    chk({tag, "_fdone"},  n_fd,   1);
    chk({tag, "_fd_lat"}, fd_cyc - last_intr_cyc, 1);
    chk({tag, "_padtop"}, n_pt, LB);
    chk({tag, "_padbot"}, n_pb, LB);
    chk({tag, "_padbot_early"}, n_pb_early, 0);
    chk({tag, "_addr_seq"}, n_addr_err, 0);
  endtask

  initial begin
    bit saw_rdy;
    bit hit;

    // Reset with tvalid held high
    rst = 1'b1; s_axis_tvalid = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    clr_cnt();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tready", int'(s_tready), 0);
      chk("rst_wr_en",  int'(s_wr_en),  0);
      chk("rst_pulses", int'({s_intr, s_fd, s_wv, s_rd_en}), 0);
    end
    rst = 1'b0; s_axis_tvalid = 1'b0; m_ready = 1'b1;
    tick();
    chk("tready_after_rst", int'(s_tready), 1);
    chk("idle_geometry", int'({s_pad_top, s_pad_bot, s_top}), 0);

    // Two rows back to back, reads follow
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1;
      tick();
      chk("wr_en_seq",   int'(s_wr_en),   (i < 4) ? 1 : 2);
      chk("wr_addr_seq", int'(s_wr_addr), i % 4);
    end
    s_axis_tvalid = 1'b0;
    tick();
    chk("rd_en_early", int'(s_rd_en), 0);
    tick();
    chk("rd_en_first", int'(s_rd_en), 1);
    chk("pad_top_row0", int'(s_pad_top), 1);
    chk("top_line_row0", int'(s_top), 3);
    chk("rd_addr0", int'(s_rd_addr), 0);
    tick();
    chk("wvalid_lat", int'(s_wv), 1);
    chk("rd_addr1", int'(s_rd_addr), 1);
    tick();
    tick();
    chk("rd_addr3", int'(s_rd_addr), 3);
    chk("wlast_early", int'(s_wl), 0);
    tick();
    chk("row0_intr", int'(s_intr), 1);
    chk("row0_wlast", int'({s_wv, s_wl}), 3);
    chk("row_end_rd_en", int'(s_rd_en), 0);

    // Fill all four buffers with nobody reading
    do_reset();
    s_axis_tvalid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    chk("fill_accepted", n_hs, 16);
    chk("fill_tready", int'(s_tready), 0);
    m_ready = 1'b1;
    saw_rdy = 0;
    for (int i = 0; i < 40 && n_intr < 2; i++) begin
      tick();
      if (s_tready) saw_rdy = 1;
    end
    chk("fill_two_rows", n_intr, 2);
    chk("fill_no_early_ready", int'(saw_rdy), 0);
    chk("fill_still_16", n_hs, 16);
    tick();
    chk("fill_release_ready", int'(s_tready), 1);
    s_axis_tvalid = 1'b0;

    // Full frames, then another straight after
    do_reset();
    run_frame(1'b0, "f1");
    run_frame(1'b0, "f2");

    // Downstream stalls every other cycle
    do_reset();
    run_frame(1'b1, "tog");

    // Reset in the middle of row 2
    do_reset();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      s_axis_tvalid = (n_hs < LB * NR);
      m_ready = 1'b1;
      tick();
      if (n_intr == 2 && s_rd_en) hit = 1;
    end
    chk("mid_row2_reached", int'(hit), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; s_axis_tvalid = 1'b0;
    clr_cnt();
    tick();
    chk("mrst_rd_en", int'(s_rd_en), 0);
    chk("mrst_wr_en", int'(s_wr_en), 0);
    chk("mrst_wvalid", int'(s_wv), 0);
    chk("mrst_tready", int'(s_tready), 1);
    chk("mrst_geometry", int'({s_pad_top, s_top}), 0);
    tick(); tick(); tick();
    chk("mrst_no_intr", n_intr + n_fd, 0);
    run_frame(1'b0, "f3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
